// File: rtl/cf_math_pkg.sv
// Shared arithmetic helpers for sizing index and counter fields.
package cf_math_pkg;

   // Bits needed to index num_idx items; a single item still gets one bit.
   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: position of the lowest set bit, plus an all-zero flag.
module lzc
   import cf_math_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]            in_i,
   output logic [idx_width(WIDTH)-1:0] cnt_o,
   output logic                        empty_o
);

   localparam int unsigned CntWidth = idx_width(WIDTH);

   // Scanning downwards leaves the lowest set bit as the final assignment.
   always_comb begin
      cnt_o = '0;
      for (int unsigned i = WIDTH; i > 0; i--) begin
         if (in_i[i-1]) cnt_o = CntWidth'(i - 1);
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/stream_burst_arbiter.sv
// Round-robin stream arbiter that keeps a granted requester for up to MaxBurst beats.
module stream_burst_arbiter
   import cf_math_pkg::*;
#(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxBurst  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [DataWidth-1:0]         inp_data_i [NumReq],
   input  logic [NumReq-1:0]            inp_valid_i,
   output logic [NumReq-1:0]            inp_ready_o,
   output logic [DataWidth-1:0]         oup_data_o,
   output logic [idx_width(NumReq)-1:0] oup_idx_o,
   output logic                         oup_valid_o,
   input  logic                         oup_ready_i
);

   localparam int unsigned IdxWidth  = idx_width(NumReq);
   localparam int unsigned BeatWidth = $clog2(MaxBurst + 1);

   typedef enum logic {
      StIdle,
      StOwn
   } state_e;

   state_e                 state_q, state_d;
   logic [IdxWidth-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IdxWidth-1:0]    owner_q, owner_d;
   logic [BeatWidth-1:0]   beat_cnt_q, beat_cnt_d;

   logic [NumReq-1:0]      rot_valid;
   logic [IdxWidth-1:0]    rot_cnt;
   logic                   rot_empty;
   logic [IdxWidth-1:0]    sel;
   logic [IdxWidth-1:0]    idx;
   logic                   valid;
   logic [BeatWidth-1:0]   beat_inc;

   // Modulo-NumReq add; both operands are below NumReq, so one subtraction suffices.
   function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] a,
                                                    input logic [IdxWidth-1:0] b);
      logic [IdxWidth:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IdxWidth+1)'(NumReq)) s = s - (IdxWidth+1)'(NumReq);
      return s[IdxWidth-1:0];
   endfunction

   always_comb begin
      rot_valid = '0;
      for (int unsigned j = 0; j < NumReq; j++) begin
         rot_valid[j] = inp_valid_i[wrap_add(rr_ptr_q, IdxWidth'(j))];
      end
   end

   lzc #(
      .WIDTH (NumReq)
   ) u_lzc (
      .in_i    (rot_valid),
      .cnt_o   (rot_cnt),
      .empty_o (rot_empty)
   );

   assign sel      = wrap_add(rr_ptr_q, rot_cnt);
   assign beat_inc = BeatWidth'(beat_cnt_q + BeatWidth'(1));

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      idx        = sel;
      valid      = 1'b0;

      unique case (state_q)
         StIdle: begin
            idx   = sel;
            valid = ~rot_empty;
            if (valid) begin
               if (oup_ready_i && (MaxBurst == 1)) begin
                  rr_ptr_d = wrap_add(sel, IdxWidth'(1));
               end else begin
                  // A stalled first beat also locks the owner so the output stays stable.
                  state_d    = StOwn;
                  owner_d    = sel;
                  beat_cnt_d = oup_ready_i ? BeatWidth'(1) : '0;
               end
            end
         end
         StOwn: begin
            idx   = owner_q;
            valid = inp_valid_i[owner_q];
            if (!valid) begin
               state_d    = StIdle;
               rr_ptr_d   = wrap_add(owner_q, IdxWidth'(1));
               beat_cnt_d = '0;
            end else if (oup_ready_i) begin
               if (beat_inc == BeatWidth'(MaxBurst)) begin
                  state_d    = StIdle;
                  rr_ptr_d   = wrap_add(owner_q, IdxWidth'(1));
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_inc;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (rst_i) begin
         valid = 1'b0;
         idx   = '0;
      end
   end

   always_comb begin
      inp_ready_o = '0;
      if (valid && oup_ready_i) inp_ready_o[idx] = 1'b1;
   end

   assign oup_valid_o = valid;
   assign oup_idx_o   = idx;
   assign oup_data_o  = inp_data_i[idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Directed vector table plus scoreboarded random traffic for stream_burst_arbiter.
module tb_stream_burst_arbiter;

   localparam int unsigned NumReq    = 4;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned MaxBurst  = 2;
   localparam int          RandCycles = 10000;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [DataWidth-1:0] inp_data [NumReq];
   logic [NumReq-1:0]    inp_valid;
   logic [NumReq-1:0]    inp_ready;
   logic [DataWidth-1:0] oup_data;
   logic [1:0]           oup_idx;
   logic                 oup_valid;
   logic                 oup_ready;

   always #5 clk = ~clk;

   stream_burst_arbiter #(
      .NumReq    (NumReq),
      .DataWidth (DataWidth),
      .MaxBurst  (MaxBurst)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .inp_data_i  (inp_data),
      .inp_valid_i (inp_valid),
      .inp_ready_o (inp_ready),
      .oup_data_o  (oup_data),
      .oup_idx_o   (oup_idx),
      .oup_valid_o (oup_valid),
      .oup_ready_i (oup_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour of the arbiter state machine.
   bit m_own;
   int m_rr, m_owner, m_cnt;

   function automatic void model_out(input logic r, input logic [3:0] v,
                                     output logic mv, output logic [1:0] mi);
      mv = 1'b0;
      mi = 2'd0;
      if (r) return;
      if (!m_own) begin
         for (int k = 0; k < NumReq; k++) begin
            int c;
            c = (m_rr + k) % NumReq;
            if (v[c] && !mv) begin
               mv = 1'b1;
               mi = 2'(c);
            end
         end
      end else begin
         mi = 2'(m_owner);
         mv = v[m_owner];
      end
   endfunction

   function automatic void model_next(input logic r, input logic [3:0] v, input logic rdy);
      logic mv;
      logic [1:0] mi;
      model_out(r, v, mv, mi);
      if (r) begin
         m_own = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
      end else if (!m_own) begin
         if (mv) begin
            if (rdy && MaxBurst == 1) m_rr = (int'(mi) + 1) % NumReq;
            else begin
               m_own = 1; m_owner = int'(mi); m_cnt = rdy ? 1 : 0;
            end
         end
      end else if (!mv) begin
         m_own = 0; m_rr = (m_owner + 1) % NumReq; m_cnt = 0;
      end else if (rdy) begin
         m_cnt++;
         if (m_cnt == MaxBurst) begin
            m_own = 0; m_rr = (m_owner + 1) % NumReq; m_cnt = 0;
         end
      end
   endfunction

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic       ready;
      logic       ev;
      logic [1:0] ei;
      logic [3:0] er;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] v, input logic rdy,
                      input logic ev, input logic [1:0] ei, input logic [3:0] er);
      vec_t t;
      t.rst = r; t.valid = v; t.ready = rdy; t.ev = ev; t.ei = ei; t.er = er;
      tbl.push_back(t);
   endtask

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] data;
   } beat_t;

   beat_t sb_q[$];

   logic [31:0] tdata [NumReq];
   bit          src_valid [NumReq];
   int          seq [NumReq];
   int          wait_beats [NumReq];
   int          beats_total;

   initial begin
      logic       mv;
      logic [1:0] mi;
      logic [3:0] exp_rdy;
      beat_t      b;

      m_own = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
      for (int i = 0; i < NumReq; i++) begin
         tdata[i]    = 32'hCAFE_0000 + 32'(i * 17);
         inp_data[i] = tdata[i];
      end

      // Reset with traffic present: outputs forced quiet.
      add(1, 4'b1111, 1, 0, 2'd0, 4'b0000);
      add(1, 4'b0100, 1, 0, 2'd0, 4'b0000);
      // All valid, always ready: two beats each, round robin.
      for (int k = 0; k < 10; k++) begin
         logic [1:0] ii;
         logic [3:0] one;
         ii  = 2'((k / 2) % 4);
         one = 4'b0001 << ii;
         add(0, 4'b1111, 1, 1, ii, one);
      end
      add(1, 4'b0000, 0, 0, 2'd0, 4'b0000);
      // Stalled single requester, then release, then owner drops valid.
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0000);
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0000);
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0000);
      add(0, 4'b0100, 1, 1, 2'd2, 4'b0100);
      add(0, 4'b0000, 1, 0, 2'd0, 4'b0000);
      add(1, 4'b0100, 0, 0, 2'd0, 4'b0000);
      // Owner drop gives one bubble; then burst on 3 wraps the pointer to 0.
      add(0, 4'b0010, 1, 1, 2'd1, 4'b0010);
      add(0, 4'b1000, 1, 0, 2'd0, 4'b0000);
      add(0, 4'b1000, 1, 1, 2'd3, 4'b1000);
      add(0, 4'b1001, 1, 1, 2'd3, 4'b1000);
      add(0, 4'b1001, 1, 1, 2'd0, 4'b0001);
      add(1, 4'b0000, 0, 0, 2'd0, 4'b0000);
      // Reset mid-burst on owner 2 returns to IDLE with pointer 0.
      add(0, 4'b0100, 1, 1, 2'd2, 4'b0100);
      add(1, 4'b0101, 1, 0, 2'd0, 4'b0000);
      add(0, 4'b0101, 1, 1, 2'd0, 4'b0001);

      for (int i = 0; i < tbl.size(); i++) begin
         rst       = tbl[i].rst;
         inp_valid = tbl[i].valid;
         oup_ready = tbl[i].ready;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 64'(oup_valid), 64'(tbl[i].ev));
         check($sformatf("vec%0d_ready", i), 64'(inp_ready), 64'(tbl[i].er));
         if (tbl[i].ev || tbl[i].rst)
            check($sformatf("vec%0d_idx", i), 64'(oup_idx), 64'(tbl[i].ei));
         if (tbl[i].ev)
            check($sformatf("vec%0d_data", i), 64'(oup_data), 64'(tdata[tbl[i].ei]));
         model_next(rst, inp_valid, oup_ready);
         @(posedge clk);
         #1;
      end

      // Random traffic with a beat scoreboard and a starvation bound.
      rst = 1'b0;
      beats_total = 0;
      for (int i = 0; i < NumReq; i++) begin
         src_valid[i] = 1'b0; seq[i] = 0; wait_beats[i] = 0;
      end
      for (int c = 0; c < RandCycles; c++) begin
         for (int i = 0; i < NumReq; i++) begin
            inp_valid[i] = src_valid[i];
            inp_data[i]  = {8'(i), 24'(seq[i])};
         end
         oup_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         model_out(1'b0, inp_valid, mv, mi);
         if (mv && oup_ready) begin
            b.idx = mi; b.data = inp_data[mi];
            sb_q.push_back(b);
         end
         exp_rdy = (mv && oup_ready) ? (4'b0001 << mi) : 4'b0000;
         check("rnd_valid", 64'(oup_valid), 64'(mv));
         check("rnd_ready", 64'(inp_ready), 64'(exp_rdy));
         check("rnd_onehot", 64'($countones(inp_ready) <= 1), 64'(1));
         if (oup_valid && oup_ready) begin
            if (sb_q.size() == 0) begin
               check("rnd_unexpected_beat", 64'(1), 64'(0));
            end else begin
               b = sb_q.pop_front();
               check("rnd_beat_idx", 64'(oup_idx), 64'(b.idx));
               check("rnd_beat_data", 64'(oup_data), 64'(b.data));
            end
            beats_total++;
            for (int i = 0; i < NumReq; i++) begin
               if (i == int'(oup_idx)) begin
                  check("rnd_starve", 64'(wait_beats[i] <= (NumReq - 1) * MaxBurst), 64'(1));
                  wait_beats[i] = 0;
               end else if (inp_valid[i]) begin
                  wait_beats[i]++;
               end
            end
         end
         for (int i = 0; i < NumReq; i++) begin
            if (!inp_valid[i]) wait_beats[i] = 0;
         end
         model_next(1'b0, inp_valid, oup_ready);
         for (int i = 0; i < NumReq; i++) begin
            if (inp_ready[i]) begin
               seq[i]++;
               src_valid[i] = ($urandom_range(0, 1) == 1);
            end else if (src_valid[i]) begin
               if ($urandom_range(0, 15) == 0) src_valid[i] = 1'b0;
            end else begin
               src_valid[i] = ($urandom_range(0, 1) == 1);
            end
         end
         @(posedge clk);
         #1;
      end
      check("rnd_sb_drained", 64'(sb_q.size()), 64'(0));
      check("rnd_traffic_seen", 64'(beats_total > RandCycles / 4), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
